// File: rtl/fetchflare_fifo_pkg.sv
// ---------------------------------------------------------------------------
// fetchflare_fifo_pkg
// Shared sizing helpers for the BRAM FIFO read-side logic.
//   log2c        : ceil(log2(value)), never less than 1 (usable as a width)
//   occ_width    : bits needed to hold an occupancy of 0..depth
//   credit_width : bits needed to hold occupancy + one in-flight word
// Default parameter values for the stream reader are kept here as well.
// ---------------------------------------------------------------------------
package fetchflare_fifo_pkg;

    localparam int DEFAULT_DW        = 160;
    localparam int DEFAULT_BUF_DEPTH = 2;
    localparam int DEFAULT_CNT_W     = 32;

    function automatic int log2c(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int occ_width(input int depth);
        return log2c(depth + 1);
    endfunction

    // Occupancy can reach depth while a word is still returning from the
    // FIFO, so the credit sum needs room for depth + 1.
    function automatic int credit_width(input int depth);
        return log2c(depth + 2);
    endfunction

endpackage

// File: rtl/bram_fifo_rd_skid.sv
// ---------------------------------------------------------------------------
// bram_fifo_rd_skid
// Small circular output buffer for the stream reader.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   push         : write push_data at the tail this cycle
//   push_data    : word to store
//   pop          : head entry consumed this cycle
//   flush        : clear head, tail and occupancy at the next edge
//   head_data    : registered head entry (no path from push_data)
//   occ          : current number of stored words
// The caller guarantees push never happens when the buffer is full.
// ---------------------------------------------------------------------------
module bram_fifo_rd_skid
    import fetchflare_fifo_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_BUF_DEPTH,
    parameter int OCC_W = occ_width(DEFAULT_BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [DW-1:0]    head_data,
    output logic [OCC_W-1:0] occ
);

    localparam int PTR_W = log2c(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        mem_d  = mem_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = push_data;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            mem_q  <= mem_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign occ       = occ_q;

endmodule

// File: rtl/bram_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_fifo_stream_reader
// Drains a BRAM FIFO with a 1-cycle registered dout and re-presents the
// words as a valid/ready stream, sustaining one word per cycle.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   flush        : drop buffered and in-flight words (synchronous)
//   fifo_empty   : FIFO empty flag
//   fifo_dout    : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   : FIFO read strobe (combinational)
//   m_valid/m_data/m_ready : output stream
//   buf_occ      : output buffer occupancy
//   xfer_cnt     : delivered-word counter
// Optional feature: define FETCHFLARE_RD_STATS_EN to build the xfer_cnt
// counter (wraps, cleared only by reset). Otherwise xfer_cnt is 0.
// ---------------------------------------------------------------------------
module bram_fifo_stream_reader
    import fetchflare_fifo_pkg::*;
#(
    parameter int DW        = DEFAULT_DW,
    parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             fifo_empty,
    input  logic [DW-1:0]                    fifo_dout,
    output logic                             fifo_rd_en,
    output logic                             m_valid,
    output logic [DW-1:0]                    m_data,
    input  logic                             m_ready,
    output logic [occ_width(BUF_DEPTH)-1:0]  buf_occ,
    output logic [CNT_W-1:0]                 xfer_cnt
);

    localparam int OCC_W = occ_width(BUF_DEPTH);
    localparam int CR_W  = credit_width(BUF_DEPTH);
    localparam logic [CR_W-1:0] DEPTH_C = CR_W'(BUF_DEPTH);

    logic            inflight_q, inflight_d;
    logic            pop;
    logic            push;
    logic [CR_W-1:0] credit;

    assign m_valid = (buf_occ != '0);
    assign pop     = m_valid & m_ready;
    // A word returning during a flush is discarded on purpose.
    assign push    = inflight_q & ~flush;

    // Credit counts stored words plus the word still coming back from the
    // FIFO, minus the one leaving this cycle. pop implies buf_occ >= 1, so
    // the subtraction cannot underflow. Reset gates the strobe so the FIFO
    // sees no read while this block is held in reset.
    always_comb begin
        credit     = CR_W'(buf_occ) + CR_W'(inflight_q) - CR_W'(pop);
        fifo_rd_en = reset & ~fifo_empty & ~flush & (credit < DEPTH_C);
        inflight_d = fifo_rd_en;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    bram_fifo_rd_skid #(
        .DW    (DW),
        .DEPTH (BUF_DEPTH),
        .OCC_W (OCC_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (fifo_dout),
        .pop       (pop),
        .flush     (flush),
        .head_data (m_data),
        .occ       (buf_occ)
    );

`ifdef FETCHFLARE_RD_STATS_EN
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    // Flush does not touch the counter: words popped are already delivered.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (pop) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_bram_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_fifo_stream_reader
// Bench for bram_fifo_stream_reader fed by a 16-deep, 160-bit FIFO model with
// registered read data. Scenarios: burst, stall, random traffic, flush with
// an in-flight word, asynchronous reset mid-stream, transfer counter.
// ---------------------------------------------------------------------------
module tb_bram_fifo_stream_reader;

    localparam int DW = 160;
    localparam int FD = 16;
`ifdef FETCHFLARE_RD_STATS_EN
    localparam logic [31:0] EXP_CNT_S1 = 32'd8;
`else
    localparam logic [31:0] EXP_CNT_S1 = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          m_ready = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] fifo_dout;
    logic [DW-1:0] m_data;
    logic [1:0]    buf_occ;
    logic [31:0]   xfer_cnt;

    always #5 clk = ~clk;

    bram_fifo_stream_reader #(
        .DW        (DW),
        .BUF_DEPTH (2),
        .CNT_W     (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .buf_occ    (buf_occ),
        .xfer_cnt   (xfer_cnt)
    );

    // FIFO model: registered dout, reads ignored when empty.
    logic [DW-1:0] fmem [FD];
    logic [3:0]    fwp, frp;
    logic [4:0]    fcnt;
    logic          f_wr, f_rd;
    assign fifo_empty = (fcnt == 5'd0);
    assign f_wr = wr_en && (fcnt != 5'd16);
    assign f_rd = fifo_rd_en && (fcnt != 5'd0);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwp       <= '0;
            frp       <= '0;
            fcnt      <= '0;
            fifo_dout <= '0;
        end else begin
            if (f_wr) begin
                fmem[fwp] <= din;
                fwp       <= fwp + 4'd1;
            end
            if (f_rd) begin
                fifo_dout <= fmem[frp];
                frp       <= frp + 4'd1;
            end
            fcnt <= fcnt + 5'(f_wr) - 5'(f_rd);
        end
    end

    typedef struct {
        logic          wr;
        logic [DW-1:0] din;
        logic          rdy;
        logic          e_rd;
        logic          e_val;
        logic [DW-1:0] e_dat;
    } vec_t;

    vec_t          tbl [12];
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] sb [$];
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle checks: no FIFO underflow, occupancy bound, stall stability,
    // and scoreboard ordering of every accepted word.
    task automatic monitor();
        chk("no_underflow", DW'(fifo_rd_en & fifo_empty), '0);
        chk("occ_bound", DW'(buf_occ <= 2'd2), DW'(1));
        if (prev_hold) begin
            chk("stall_valid", DW'(m_valid), DW'(1));
            chk("stall_data", m_data, prev_data);
        end
        if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got 0x%0h expected no word", m_data);
            end else begin
                chk("sb_data", m_data, sb.pop_front());
            end
        end
        prev_hold = m_valid && !m_ready && !flush;
        prev_data = m_data;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic put(input logic [DW-1:0] w);
        wr_en = 1'b1;
        din   = w;
        sb.push_back(w);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            rd_cnt;
        int            sent;
        int            cyc;
        logic [DW-1:0] w;

        for (int c = 0; c < 12; c++) begin
            tbl[c].wr    = (c < 8);
            tbl[c].din   = DW'(c + 1);
            tbl[c].rdy   = 1'b1;
            tbl[c].e_rd  = (c >= 1) && (c <= 8);
            tbl[c].e_val = (c >= 3) && (c <= 10);
            tbl[c].e_dat = tbl[c].e_val ? DW'(c - 2) : '0;
        end

        // Reset state
        #1 reset = 1'b0;
        #1;
        chk("rst_rd_en", DW'(fifo_rd_en), '0);
        chk("rst_valid", DW'(m_valid), '0);
        chk("rst_data", m_data, '0);
        chk("rst_occ", DW'(buf_occ), '0);
        chk("rst_xfer", DW'(xfer_cnt), '0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // 1: burst without backpressure
        for (int c = 0; c < 12; c++) begin
            drive_edge();
            m_ready = tbl[c].rdy;
            if (tbl[c].wr) put(tbl[c].din);
            else wr_en = 1'b0;
            sample();
            chk($sformatf("s1_rd_en[%0d]", c), DW'(fifo_rd_en), DW'(tbl[c].e_rd));
            chk($sformatf("s1_valid[%0d]", c), DW'(m_valid), DW'(tbl[c].e_val));
            if (tbl[c].e_val) chk($sformatf("s1_data[%0d]", c), m_data, tbl[c].e_dat);
        end
        chk("s1_xfer_cnt", DW'(xfer_cnt), DW'(EXP_CNT_S1));

        // 2: stalled consumer
        rd_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            drive_edge();
            m_ready = 1'b0;
            if (k < 5) put(DW'(k + 1));
            else wr_en = 1'b0;
            sample();
            if (fifo_rd_en) rd_cnt++;
        end
        chk("s2_reads", DW'(rd_cnt), DW'(2));
        chk("s2_occ", DW'(buf_occ), DW'(2));
        chk("s2_head", m_data, DW'(1));
        for (int k = 0; k < 5; k++) begin
            drive_edge();
            m_ready = 1'b1;
            sample();
            chk($sformatf("s2_rel_valid[%0d]", k), DW'(m_valid), DW'(1));
            chk($sformatf("s2_rel_data[%0d]", k), m_data, DW'(k + 1));
        end
        drive_edge();
        sample();
        chk("s2_drained", DW'(m_valid), '0);

        // 3: random traffic and backpressure
        sent = 0;
        cyc  = 0;
        while ((sent < 1000 || sb.size() != 0) && cyc < 20000) begin
            drive_edge();
            m_ready = 1'($urandom_range(0, 1));
            if (sent < 1000 && fcnt < 5'd16 && $urandom_range(0, 1) == 1) begin
                put({$urandom, $urandom, $urandom, $urandom, $urandom});
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            sample();
            cyc++;
        end
        chk("s3_sent", DW'(sent), DW'(1000));
        chk("s3_left", DW'(sb.size()), '0);
        drive_edge();
        wr_en   = 1'b0;
        m_ready = 1'b1;
        sample();

        // 4: flush while the first word is returning
        drive_edge();
        put(DW'(160'hA1));
        sample();
        chk("s4_rd_w0", DW'(fifo_rd_en), '0);
        drive_edge();
        put(DW'(160'hB2));
        sample();
        chk("s4_rd_w1", DW'(fifo_rd_en), DW'(1));
        drive_edge();
        put(DW'(160'hC3));
        flush = 1'b1;
        sample();
        chk("s4_rd_flush", DW'(fifo_rd_en), '0);
        w = sb.pop_front();   // the in-flight word is lost by design
        drive_edge();
        wr_en = 1'b0;
        flush = 1'b0;
        sample();
        chk("s4_valid_after", DW'(m_valid), '0);
        chk("s4_rd_resume", DW'(fifo_rd_en), DW'(1));
        drive_edge();
        sample();
        chk("s4_valid_w4", DW'(m_valid), '0);
        drive_edge();
        sample();
        chk("s4_valid_w5", DW'(m_valid), DW'(1));
        chk("s4_data_w5", m_data, DW'(160'hB2));
        drive_edge();
        sample();
        chk("s4_data_w6", m_data, DW'(160'hC3));
        drive_edge();
        sample();
        chk("s4_valid_w7", DW'(m_valid), '0);
        chk("s4_left", DW'(sb.size()), '0);

        // 5: asynchronous reset with a full buffer
        for (int k = 0; k < 6; k++) begin
            drive_edge();
            m_ready = 1'b0;
            if (k < 3) put(DW'(160'hD0 + k));
            else wr_en = 1'b0;
            sample();
        end
        chk("s5_occ", DW'(buf_occ), DW'(2));
        chk("s5_head", m_data, DW'(160'hD0));
        #2 reset = 1'b0;
        #1;
        chk("s5_rst_rd_en", DW'(fifo_rd_en), '0);
        chk("s5_rst_valid", DW'(m_valid), '0);
        chk("s5_rst_data", m_data, '0);
        chk("s5_rst_occ", DW'(buf_occ), '0);
        chk("s5_rst_xfer", DW'(xfer_cnt), '0);
        prev_hold = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_edge();
            sample();
            chk($sformatf("s5_idle[%0d]", k), DW'(m_valid), '0);
        end
        drive_edge();
        m_ready = 1'b1;
        put(DW'(160'hE7));
        sample();
        drive_edge();
        wr_en = 1'b0;
        sample();
        for (int k = 0; k < 4; k++) begin
            drive_edge();
            sample();
        end
        chk("s5_recover_left", DW'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
